// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 16-bit memory port between the 68k bus and the
// SPI loader word port; generates DTACKn/BERRn and fair or CPU-held arbitration.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   cpu_hold                  1 = CPU accesses blocked (loader owns memory)
//   cpu_as_n/rw/uds_n/lds_n   68k bus strobes
//   cpu_addr, cpu_dout        CPU word address / write data
//   cpu_din                   registered read data to CPU
//   cpu_dtack_n, cpu_berr_n   CPU cycle termination
//   spi_req/we/be/addr/wdata  SPI word request (level, held until spi_ack)
//   spi_rdata, spi_ack        registered read data, one-cycle done pulse
//   spi_err                   valid with spi_ack, 1 = timed out
//   mem_req/we/be/addr/wdata  memory request (held until mem_ack)
//   mem_rdata, mem_ack        memory read data, one-cycle completion

module mem_bus_arbiter #(
  parameter int ADDR_BITS = 23,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_hold,
  input  logic                 cpu_as_n,
  input  logic                 cpu_rw,
  input  logic                 cpu_uds_n,
  input  logic                 cpu_lds_n,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [15:0]          cpu_dout,
  output logic [15:0]          cpu_din,
  output logic                 cpu_dtack_n,
  output logic                 cpu_berr_n,
  input  logic                 spi_req,
  input  logic                 spi_we,
  input  logic [1:0]           spi_be,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [15:0]          spi_wdata,
  output logic [15:0]          spi_rdata,
  output logic                 spi_ack,
  output logic                 spi_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [1:0]           mem_be,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [15:0]          mem_wdata,
  input  logic [15:0]          mem_rdata,
  input  logic                 mem_ack
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    CPU_END,
    SPI_ACC
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_spi_q, last_spi_d;
  logic                   served_q, served_d;
  logic                   issued_q, issued_d;
  logic                   abort_q, abort_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [1:0]             mem_be_q, mem_be_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]            mem_wdata_q, mem_wdata_d;
  logic [15:0]            cpu_din_q, cpu_din_d;
  logic                   dtack_n_q, dtack_n_d;
  logic                   berr_n_q, berr_n_d;
  logic [15:0]            spi_rdata_q, spi_rdata_d;
  logic                   spi_ack_q, spi_ack_d;
  logic                   spi_err_q, spi_err_d;

  logic cpu_req;
  logic ack;
  logic timed_out;
  logic cpu_gone;

  assign cpu_req   = !cpu_as_n
                   && (!cpu_uds_n || !cpu_lds_n)
                   && !served_q;
  // An ack only counts once the request is actually on the port.
  assign ack       = mem_ack && mem_req_q;
  assign timed_out = (cnt_q == TO_CNT);
  // AS released now or earlier in this access: the 68k gave up the cycle.
  assign cpu_gone  = abort_q || cpu_as_n;

  always_comb begin
    state_d     = state_q;
    last_spi_d  = last_spi_q;
    served_d    = served_q;
    issued_d    = issued_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_din_d   = cpu_din_q;
    dtack_n_d   = dtack_n_q;
    berr_n_d    = berr_n_q;
    spi_rdata_d = spi_rdata_q;
    spi_ack_d   = 1'b0;
    spi_err_d   = spi_err_q;

    if (cpu_as_n) begin
      served_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d    = 8'd0;
        issued_d = 1'b0;
        abort_d  = 1'b0;
        // SPI wins unless a CPU request is pending and SPI went last.
        if (spi_req
            && (cpu_hold || !cpu_req || !last_spi_q)) begin
          state_d     = SPI_ACC;
          mem_we_d    = spi_we;
          mem_be_d    = spi_be;
          mem_addr_d  = spi_addr;
          mem_wdata_d = spi_wdata;
        end else if (cpu_req && !cpu_hold) begin
          state_d     = CPU_ACC;
          served_d    = 1'b1;
          mem_we_d    = !cpu_rw;
          mem_be_d    = {!cpu_uds_n, !cpu_lds_n};
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_dout;
        end
      end

      CPU_ACC: begin
        cnt_d = cnt_q + 8'd1;
        if (!issued_q) begin
          mem_req_d = 1'b1;
          issued_d  = 1'b1;
        end
        if (cpu_as_n) begin
          abort_d = 1'b1;
        end
        if (ack) begin
          mem_req_d = 1'b0;
          if (cpu_gone) begin
            state_d = IDLE;
          end else begin
            if (!mem_we_q) begin
              cpu_din_d = mem_rdata;
            end
            dtack_n_d  = 1'b0;
            last_spi_d = 1'b0;
            state_d    = CPU_END;
          end
        end else if (timed_out) begin
          mem_req_d = 1'b0;
          if (cpu_gone) begin
            state_d = IDLE;
          end else begin
            berr_n_d = 1'b0;
            state_d  = CPU_END;
          end
        end
      end

      CPU_END: begin
        if (cpu_as_n) begin
          dtack_n_d = 1'b1;
          berr_n_d  = 1'b1;
          state_d   = IDLE;
        end
      end

      SPI_ACC: begin
        cnt_d = cnt_q + 8'd1;
        if (!issued_q) begin
          mem_req_d = 1'b1;
          issued_d  = 1'b1;
        end
        if (ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            spi_rdata_d = mem_rdata;
          end
          spi_ack_d  = 1'b1;
          spi_err_d  = 1'b0;
          last_spi_d = 1'b1;
          state_d    = IDLE;
        end else if (timed_out) begin
          mem_req_d = 1'b0;
          spi_ack_d = 1'b1;
          spi_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_spi_q  <= 1'b0;
      served_q    <= 1'b0;
      issued_q    <= 1'b0;
      abort_q     <= 1'b0;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      cpu_din_q   <= 16'h0000;
      dtack_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
      spi_rdata_q <= 16'h0000;
      spi_ack_q   <= 1'b0;
      spi_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_spi_q  <= last_spi_d;
      served_q    <= served_d;
      issued_q    <= issued_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_din_q   <= cpu_din_d;
      dtack_n_q   <= dtack_n_d;
      berr_n_q    <= berr_n_d;
      spi_rdata_q <= spi_rdata_d;
      spi_ack_q   <= spi_ack_d;
      spi_err_q   <= spi_err_d;
    end
  end

  assign cpu_din     = cpu_din_q;
  assign cpu_dtack_n = dtack_n_q;
  assign cpu_berr_n  = berr_n_q;
  assign spi_rdata   = spi_rdata_q;
  assign spi_ack     = spi_ack_q;
  assign spi_err     = spi_err_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

  a_req_idle: assert property (
    @(posedge clk) disable iff (!reset_n)
    !((state_q == IDLE || state_q == CPU_END) && mem_req_q));

  a_term_excl: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(!dtack_n_q && !berr_n_q));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter (TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_mem_bus_arbiter;

  localparam int AW = 23;

  logic          clk;
  logic          reset_n;
  logic          cpu_hold;
  logic          cpu_as_n;
  logic          cpu_rw;
  logic          cpu_uds_n;
  logic          cpu_lds_n;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_dout;
  logic [15:0]   cpu_din;
  logic          cpu_dtack_n;
  logic          cpu_berr_n;
  logic          spi_req;
  logic          spi_we;
  logic [1:0]    spi_be;
  logic [AW-1:0] spi_addr;
  logic [15:0]   spi_wdata;
  logic [15:0]   spi_rdata;
  logic          spi_ack;
  logic          spi_err;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_ack;

  int n_chk;
  int n_fail;

  mem_bus_arbiter #(
    .ADDR_BITS(AW),
    .TIMEOUT  (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_hold   (cpu_hold),
    .cpu_as_n   (cpu_as_n),
    .cpu_rw     (cpu_rw),
    .cpu_uds_n  (cpu_uds_n),
    .cpu_lds_n  (cpu_lds_n),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_dtack_n(cpu_dtack_n),
    .cpu_berr_n (cpu_berr_n),
    .spi_req    (spi_req),
    .spi_we     (spi_we),
    .spi_be     (spi_be),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .spi_rdata  (spi_rdata),
    .spi_ack    (spi_ack),
    .spi_err    (spi_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Bounded wait for mem_req; cyc = falling edges waited.
  task automatic wait_req(output int cyc, output bit ok);
    cyc = 0;
    while (mem_req !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    ok = (mem_req === 1'b1);
  endtask

  // Called on the falling edge where mem_req is first seen high;
  // ack is sampled lat rising edges after mem_req rose.
  task automatic mem_respond(input int lat,
                             input logic [15:0] rd);
    repeat (lat - 1) @(negedge clk);
    mem_rdata = rd;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  task automatic cpu_start(input logic [AW-1:0] a,
                           input logic rw,
                           input logic uds_n,
                           input logic lds_n,
                           input logic [15:0] d);
    cpu_addr  = a;
    cpu_rw    = rw;
    cpu_uds_n = uds_n;
    cpu_lds_n = lds_n;
    cpu_dout  = d;
    cpu_as_n  = 1'b0;
  endtask

  task automatic cpu_release();
    cpu_as_n  = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    n_chk++;
    if (cpu_dtack_n !== 1'b1 || cpu_berr_n !== 1'b1) begin
      $display("FAIL reset_term: dtack_n=%b berr_n=%b want 1 1",
               cpu_dtack_n, cpu_berr_n);
      n_fail++;
    end
    n_chk++;
    if ({mem_req, mem_we, mem_be} !== 4'b0000) begin
      $display("FAIL reset_mem: req/we/be=%b want 0000",
               {mem_req, mem_we, mem_be});
      n_fail++;
    end
    n_chk++;
    if ({spi_ack, spi_err} !== 2'b00) begin
      $display("FAIL reset_spi: ack/err=%b want 00",
               {spi_ack, spi_err});
      n_fail++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        mem_rdata = 16'hFFFF;
        mem_ack   = 1'b1;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
      end
      tick();
      if (mem_req !== 1'b0 || spi_ack !== 1'b0
          || cpu_dtack_n !== 1'b1) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      $display("FAIL idle_20: %0d bad cycles want 0", bad);
      n_fail++;
    end
    n_chk++;
    if (cpu_din !== 16'h0 || spi_rdata !== 16'h0) begin
      $display("FAIL idle_rdata: cpu_din=%h spi_rdata=%h want 0 0",
               cpu_din, spi_rdata);
      n_fail++;
    end
  endtask

  task automatic test_cpu_read();
    int cyc;
    bit ok;
    cpu_start(23'h000400, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cyc, ok);
    n_chk++;
    if (!ok || cyc != 2) begin
      $display("FAIL rd_latency: ok=%b cyc=%0d want 1 2", ok, cyc);
      n_fail++;
    end
    n_chk++;
    if (mem_addr !== 23'h000400 || mem_be !== 2'b11
        || mem_we !== 1'b0) begin
      $display("FAIL rd_req: addr=%h be=%b we=%b want 000400 11 0",
               mem_addr, mem_be, mem_we);
      n_fail++;
    end
    n_chk++;
    if (cpu_dtack_n !== 1'b1) begin
      $display("FAIL rd_early_dtack: dtack_n=%b want 1", cpu_dtack_n);
      n_fail++;
    end
    mem_respond(3, 16'h4E71);
    n_chk++;
    if (cpu_dtack_n !== 1'b0 || cpu_din !== 16'h4E71
        || mem_req !== 1'b0) begin
      $display("FAIL rd_done: dtack_n=%b din=%h req=%b want 0 4e71 0",
               cpu_dtack_n, cpu_din, mem_req);
      n_fail++;
    end
    repeat (2) tick();
    n_chk++;
    if (cpu_dtack_n !== 1'b0) begin
      $display("FAIL rd_hold: dtack_n=%b want 0", cpu_dtack_n);
      n_fail++;
    end
    cpu_release();
    tick();
    n_chk++;
    if (cpu_dtack_n !== 1'b1) begin
      $display("FAIL rd_release: dtack_n=%b want 1", cpu_dtack_n);
      n_fail++;
    end
  endtask

  task automatic test_cpu_write();
    int cyc;
    bit ok;
    tick();
    cpu_start(23'h010000, 1'b0, 1'b1, 1'b0, 16'h00AB);
    wait_req(cyc, ok);
    n_chk++;
    if (!ok || mem_we !== 1'b1 || mem_be !== 2'b01
        || mem_wdata !== 16'h00AB || mem_addr !== 23'h010000) begin
      $display("FAIL wr_req: ok=%b we=%b be=%b wd=%h a=%h want 1 1 01 00ab 010000",
               ok, mem_we, mem_be, mem_wdata, mem_addr);
      n_fail++;
    end
    mem_respond(1, 16'h0);
    n_chk++;
    if (cpu_dtack_n !== 1'b0) begin
      $display("FAIL wr_dtack: dtack_n=%b want 0", cpu_dtack_n);
      n_fail++;
    end
    cpu_release();
    tick();
    n_chk++;
    if (cpu_dtack_n !== 1'b1) begin
      $display("FAIL wr_release: dtack_n=%b want 1", cpu_dtack_n);
      n_fail++;
    end
  endtask

  task automatic test_cpu_hold();
    int cyc;
    int busy;
    bit ok;
    cpu_hold  = 1'b1;
    cpu_start(23'h000300, 1'b1, 1'b0, 1'b0, 16'h0);
    spi_addr  = 23'h000050;
    spi_we    = 1'b1;
    spi_be    = 2'b11;
    spi_wdata = 16'h1234;
    spi_req   = 1'b1;
    wait_req(cyc, ok);
    n_chk++;
    if (!ok || mem_addr !== 23'h000050 || mem_we !== 1'b1
        || mem_wdata !== 16'h1234) begin
      $display("FAIL hold_spi_req: ok=%b a=%h we=%b wd=%h want 1 000050 1 1234",
               ok, mem_addr, mem_we, mem_wdata);
      n_fail++;
    end
    mem_respond(2, 16'h0);
    n_chk++;
    if (spi_ack !== 1'b1 || spi_err !== 1'b0
        || cpu_dtack_n !== 1'b1) begin
      $display("FAIL hold_spi_ack: ack=%b err=%b dtack_n=%b want 1 0 1",
               spi_ack, spi_err, cpu_dtack_n);
      n_fail++;
    end
    spi_req = 1'b0;
    tick();
    n_chk++;
    if (spi_ack !== 1'b0) begin
      $display("FAIL hold_ack_pulse: ack=%b want 0", spi_ack);
      n_fail++;
    end
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req !== 1'b0 || cpu_dtack_n !== 1'b1) busy++;
    end
    n_chk++;
    if (busy != 0) begin
      $display("FAIL hold_blocked: %0d active cycles want 0", busy);
      n_fail++;
    end
    cpu_hold = 1'b0;
    wait_req(cyc, ok);
    n_chk++;
    if (!ok || mem_addr !== 23'h000300 || mem_we !== 1'b0) begin
      $display("FAIL hold_cpu_req: ok=%b a=%h we=%b want 1 000300 0",
               ok, mem_addr, mem_we);
      n_fail++;
    end
    mem_respond(1, 16'hBEEF);
    n_chk++;
    if (cpu_dtack_n !== 1'b0 || cpu_din !== 16'hBEEF) begin
      $display("FAIL hold_cpu_done: dtack_n=%b din=%h want 0 beef",
               cpu_dtack_n, cpu_din);
      n_fail++;
    end
    cpu_release();
    tick();
  endtask

  task automatic test_spi_read();
    int cyc;
    bit ok;
    spi_addr = 23'h000123;
    spi_we   = 1'b0;
    spi_be   = 2'b10;
    spi_req  = 1'b1;
    wait_req(cyc, ok);
    n_chk++;
    if (!ok || mem_be !== 2'b10 || mem_we !== 1'b0
        || mem_addr !== 23'h000123) begin
      $display("FAIL spi_rd_req: ok=%b be=%b we=%b a=%h want 1 10 0 000123",
               ok, mem_be, mem_we, mem_addr);
      n_fail++;
    end
    mem_respond(4, 16'hA5C3);
    n_chk++;
    if (spi_ack !== 1'b1 || spi_rdata !== 16'hA5C3) begin
      $display("FAIL spi_rd_done: ack=%b rdata=%h want 1 a5c3",
               spi_ack, spi_rdata);
      n_fail++;
    end
    spi_req = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int cyc;
    bit ok;
    cpu_start(23'h000400, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cyc, ok);
    cpu_release();
    mem_respond(3, 16'h1111);
    n_chk++;
    if (!ok || cpu_dtack_n !== 1'b1 || cpu_berr_n !== 1'b1
        || cpu_din !== 16'hBEEF) begin
      $display("FAIL abort: ok=%b dtack_n=%b berr_n=%b din=%h want 1 1 1 beef",
               ok, cpu_dtack_n, cpu_berr_n, cpu_din);
      n_fail++;
    end
    tick();
    n_chk++;
    if (mem_req !== 1'b0 || cpu_dtack_n !== 1'b1) begin
      $display("FAIL abort_idle: req=%b dtack_n=%b want 0 1",
               mem_req, cpu_dtack_n);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    bit got_spi;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    spi_addr  = 23'h000100;
    spi_we    = 1'b1;
    spi_be    = 2'b11;
    spi_wdata = 16'h5A5A;
    spi_req   = 1'b1;
    cpu_start(23'h000200, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      wait_req(cyc, ok);
      got_spi = (mem_addr === 23'h000100);
      n_chk++;
      if (!ok || got_spi !== (i % 2 == 0)) begin
        $display("FAIL grant_%0d: ok=%b spi=%b want 1 %b",
                 i, ok, got_spi, (i % 2 == 0));
        n_fail++;
      end
      mem_respond(1, 16'h1000 + 16'(i));
      if (got_spi) begin
        n_chk++;
        if (spi_ack !== 1'b1) begin
          $display("FAIL grant_%0d_ack: spi_ack=%b want 1", i, spi_ack);
          n_fail++;
        end
      end else begin
        n_chk++;
        if (cpu_dtack_n !== 1'b0 || cpu_din !== 16'h1000 + 16'(i)) begin
          $display("FAIL grant_%0d_dtack: dtack_n=%b din=%h want 0 %h",
                   i, cpu_dtack_n, cpu_din, 16'h1000 + 16'(i));
          n_fail++;
        end
        cpu_as_n = 1'b1;
        if (i == 5) spi_req = 1'b0;
        tick();
        if (i != 5) cpu_as_n = 1'b0;
      end
    end
    spi_req = 1'b0;
    cpu_release();
    repeat (12) tick();
  endtask

  task automatic test_timeout_cpu();
    int cyc;
    int n;
    bit ok;
    cpu_start(23'h000777, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cyc, ok);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    n_chk++;
    if (!ok || n != 8) begin
      $display("FAIL to_cpu_len: ok=%b req_cycles=%0d want 1 8", ok, n);
      n_fail++;
    end
    n_chk++;
    if (cpu_berr_n !== 1'b0 || cpu_dtack_n !== 1'b1) begin
      $display("FAIL to_cpu_berr: berr_n=%b dtack_n=%b want 0 1",
               cpu_berr_n, cpu_dtack_n);
      n_fail++;
    end
    repeat (2) tick();
    n_chk++;
    if (cpu_berr_n !== 1'b0) begin
      $display("FAIL to_cpu_hold: berr_n=%b want 0", cpu_berr_n);
      n_fail++;
    end
    cpu_release();
    tick();
    n_chk++;
    if (cpu_berr_n !== 1'b1) begin
      $display("FAIL to_cpu_release: berr_n=%b want 1", cpu_berr_n);
      n_fail++;
    end
  endtask

  task automatic test_timeout_spi();
    int cyc;
    int n;
    bit ok;
    spi_addr = 23'h000099;
    spi_we   = 1'b0;
    spi_be   = 2'b11;
    spi_req  = 1'b1;
    wait_req(cyc, ok);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    n_chk++;
    if (!ok || n != 8) begin
      $display("FAIL to_spi_len: ok=%b req_cycles=%0d want 1 8", ok, n);
      n_fail++;
    end
    n_chk++;
    if (spi_ack !== 1'b1 || spi_err !== 1'b1) begin
      $display("FAIL to_spi_err: ack=%b err=%b want 1 1", spi_ack, spi_err);
      n_fail++;
    end
    spi_req = 1'b0;
    tick();
    n_chk++;
    if (spi_ack !== 1'b0) begin
      $display("FAIL to_spi_pulse: ack=%b want 0", spi_ack);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    cpu_start(23'h000500, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req(cyc, ok);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (!ok || mem_req !== 1'b0) begin
      $display("FAIL reset_mid: ok=%b req=%b want 1 0", ok, mem_req);
      n_fail++;
    end
    cpu_release();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (mem_req !== 1'b0 || cpu_dtack_n !== 1'b1) begin
      $display("FAIL reset_mid_after: req=%b dtack_n=%b want 0 1",
               mem_req, cpu_dtack_n);
      n_fail++;
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    cpu_hold  = 1'b0;
    cpu_as_n  = 1'b1;
    cpu_rw    = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    cpu_addr  = '0;
    cpu_dout  = 16'h0;
    spi_req   = 1'b0;
    spi_we    = 1'b0;
    spi_be    = 2'b00;
    spi_addr  = '0;
    spi_wdata = 16'h0;
    mem_rdata = 16'h0;
    mem_ack   = 1'b0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_cpu_hold();
    test_spi_read();
    test_abort();
    test_back_to_back();
    test_timeout_cpu();
    test_timeout_spi();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one 16-bit memory port (SDRAM controller or BRAM) between the fx68k CPU bus and the SPI loader word port.
- Generates CPU-side DTACKn and BERRn; replaces the tie-offs in the top level.
- Sits between the fx68k/SPI slave and the sdram/gamerom instance.
- Supports a CPU-hold mode (loader owns memory) and fair alternation otherwise.

Parameters:
ADDR_BITS, 23, word address width of memory port (cpu_a[23:1]).
TIMEOUT, 255, clk cycles waiting for mem_ack before error termination (1..255, fits 8-bit counter).

Ports:
clk  in  1  system clock (clk_cpu domain).
reset_n  in  1  asynchronous active-low reset.
cpu_hold  in  1  1 = CPU accesses blocked, SPI only (from R_cpu_control[1]).
cpu_as_n  in  1  68k address strobe.
cpu_rw  in  1  1 = read, 0 = write.
cpu_uds_n  in  1  upper data strobe.
cpu_lds_n  in  1  lower data strobe.
cpu_addr  in  ADDR_BITS  CPU word address.
cpu_dout  in  16  CPU write data.
cpu_din  out  16  registered read data to CPU.
cpu_dtack_n  out  1  data transfer acknowledge.
cpu_berr_n  out  1  bus error on timeout.
spi_req  in  1  SPI request level; held until spi_ack.
spi_we  in  1  1 = write.
spi_be  in  2  byte enables {upper, lower}.
spi_addr  in  ADDR_BITS  SPI word address.
spi_wdata  in  16  SPI write data.
spi_rdata  out  16  registered read data.
spi_ack  out  1  one-cycle completion pulse.
spi_err  out  1  valid with spi_ack; 1 = timed out.
mem_req  out  1  memory request, held until mem_ack.
mem_we  out  1  write strobe qualifier.
mem_be  out  2  byte enables.
mem_addr  out  ADDR_BITS  memory address.
mem_wdata  out  16  memory write data.
mem_rdata  in  16  memory read data, valid with mem_ack.
mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE; last_grant = CPU.
  - cpu_dtack_n = 1, cpu_berr_n = 1.
  - mem_req = 0, mem_we = 0, mem_be = 0.
  - spi_ack = 0, spi_err = 0, timeout counter = 0.
  - cpu_din and spi_rdata = 0.
  - Reset mid-transfer drops mem_req immediately; the memory side must tolerate an abandoned request.
- CPU request: cpu_as_n=0 AND (cpu_uds_n=0 OR cpu_lds_n=0) AND cpu_served=0.
  - cpu_served is set on entering CPU_ACC and cleared when cpu_as_n=1 is sampled.
- States: IDLE, CPU_ACC, CPU_END, SPI_ACC.
- IDLE:
  - Go to SPI_ACC if spi_req=1 AND (cpu_hold=1 OR no CPU request OR last_grant=CPU).
  - Otherwise go to CPU_ACC if there is a CPU request AND cpu_hold=0.
  - Result: strict alternation when both requesters are continuously pending.
  - On entry to either ACC state, latch addr/we/be/wdata into mem_* registers, assert mem_req on the next cycle, and clear the counter.
  - CPU be = {~cpu_uds_n, ~cpu_lds_n}; CPU we = ~cpu_rw.
- CPU_ACC:
  - Counter increments each cycle.
  - On mem_ack: mem_req = 0; if read, cpu_din <= mem_rdata; cpu_dtack_n <= 0; last_grant = CPU; go to CPU_END.
  - If counter == TIMEOUT without ack: mem_req = 0, cpu_berr_n <= 0, go to CPU_END.
  - If cpu_as_n rises before ack (aborted cycle): finish waiting for mem_ack, discard data, no DTACK, go to IDLE.
- CPU_END: hold dtack_n/berr_n low until cpu_as_n=1 is sampled, then drive both to 1 and go to IDLE. Minimum one cycle.
- SPI_ACC:
  - On mem_ack: spi_rdata <= mem_rdata (reads only); spi_ack = 1 for one cycle; spi_err = 0; last_grant = SPI; go to IDLE.
  - On timeout: spi_ack = 1, spi_err = 1, go to IDLE.
- mem_ack outside ACC states is ignored.
- Latency: mem_req asserts 2 clk after the request is sampled in IDLE. DTACK asserts 1 clk after mem_ack.
- cpu_hold asserted while in CPU_ACC: the current access completes; only new CPU requests are blocked.
- The SPI requester must deassert or change spi_req within 1 cycle of spi_ack. A request still high in the cycle after spi_ack is treated as a new request.

Test Plan:
- Reset release, no requests -> all outputs at reset values, mem_req=0 for 20 cycles.
- CPU read at 0x000400, mem_ack 3 clk after mem_req with rdata 0x4E71 -> mem_addr=0x000400, mem_be=2'b11, mem_we=0; cpu_din=0x4E71; cpu_dtack_n=0 until as_n rises, then 1.
- CPU byte write (lds only) 0x00AB to 0x010000 -> mem_we=1, mem_be=2'b01, mem_wdata=0x00AB, DTACK after ack.
- CPU and SPI requests pending simultaneously and continuously for 6 grants -> grants alternate SPI, CPU, SPI, CPU, SPI, CPU starting from reset.
- cpu_hold=1, CPU asserts AS, SPI writes 0x1234 -> only SPI served, spi_ack pulse, cpu_dtack_n stays 1; after cpu_hold=0 the CPU cycle completes.
- TIMEOUT=8, memory never acks a CPU read -> mem_req drops and cpu_berr_n=0 exactly 8 clk after mem_req rose; released on as_n high. Repeat for SPI -> spi_ack=1 with spi_err=1.
